instr_sequencer: RTL and testbench

- Multi-cycle fetch/decode/execute FSM that sequences the processor datapath (register file, data memory, ALU).
- Owns the PC and IR and runs a req/ack handshake to a variable-latency instruction memory.
- Drives the datapath control lines (RF read/write addresses and enables, D_addr, D_wr, ALU_s).
- Exports PC, IR and state for the top-level debug outputs.

---
 rtl/instr_sequencer.sv | 138 +++++++++++++
 tb/tb_instr_sequencer.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer.
// Owns PC/IR, handshakes with instruction memory, drives datapath controls.
module instr_sequencer #(
    parameter int PC_W = 8,
    parameter int IR_W = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    output logic            IM_req,
    output logic [PC_W-1:0] IM_addr,
    input  logic            IM_ack,
    input  logic [IR_W-1:0] IM_rdata,
    output logic [3:0]      RF_Ra_addr,
    output logic [3:0]      RF_Rb_addr,
    output logic [3:0]      RF_W_addr,
    output logic            RF_W_en,
    output logic            RF_W_sel,
    output logic [7:0]      D_addr,
    output logic            D_wr,
    output logic [2:0]      ALU_s,
    output logic            Halted,
    output logic            Illegal,
    output logic [PC_W-1:0] PC_Out,
    output logic [IR_W-1:0] IR_Out,
    output logic [7:0]      StateO,
    output logic [7:0]      NextStateO
);

    typedef enum logic [7:0] {
        INIT   = 8'd0,
        FETCH  = 8'd1,
        WAIT   = 8'd2,
        DECODE = 8'd3,
        LD_A   = 8'd4,
        LD_B   = 8'd5,
        STORE  = 8'd6,
        ALU    = 8'd7,
        HALT   = 8'd8
    } state_t;

    state_t          state;
    state_t          next;
    logic [PC_W-1:0] pc;
    logic [IR_W-1:0] ir;
    logic [3:0]      op;
    logic            take;

    assign op = ir[15:12];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= INIT;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= next;
            if (take) begin
                ir <= IM_rdata;
                pc <= pc + PC_W'(1);
            end
        end
    end

    // All controls decode from the registered state, so an async reset
    // drops IM_req and any pending write enable immediately.
    always_comb begin
        next      = state;
        take      = 1'b0;
        IM_req    = 1'b0;
        RF_W_en   = 1'b0;
        RF_W_sel  = 1'b0;
        RF_W_addr = ir[3:0];
        D_wr      = 1'b0;
        ALU_s     = 3'b000;
        Halted    = 1'b0;
        Illegal   = 1'b0;
        unique case (state)
            INIT: next = FETCH;
            FETCH, WAIT: begin
                IM_req = 1'b1;
                if (IM_ack) begin
                    take = 1'b1;
                    next = DECODE;
                end else begin
                    next = WAIT;
                end
            end
            DECODE: begin
                case (op)
                    4'h0:             next = FETCH;
                    4'h1:             next = STORE;
                    4'h2:             next = LD_A;
                    4'h3, 4'h4, 4'h5: next = ALU;
                    4'h6:             next = HALT;
                    default: begin
                        Illegal = 1'b1;
                        next    = FETCH;
                    end
                endcase
            end
            LD_A: next = LD_B;
            LD_B: begin
                RF_W_en   = 1'b1;
                RF_W_sel  = 1'b1;
                RF_W_addr = ir[11:8];
                next      = FETCH;
            end
            STORE: begin
                D_wr = 1'b1;
                next = FETCH;
            end
            ALU: begin
                RF_W_en = 1'b1;
                case (op)
                    4'h3:    ALU_s = 3'b001;
                    4'h4:    ALU_s = 3'b010;
                    default: ALU_s = 3'b011;
                endcase
                next = FETCH;
            end
            HALT: begin
                Halted = 1'b1;
                next   = HALT;
            end
            default: next = INIT;
        endcase
    end

    assign IM_addr    = pc;
    assign PC_Out     = pc;
    assign IR_Out     = ir;
    assign RF_Ra_addr = ir[11:8];
    assign RF_Rb_addr = ir[7:4];
    assign D_addr     = ir[7:0];
    assign StateO     = state;
    assign NextStateO = next;

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: directed scenarios plus a randomized
// program checked against an instruction-level reference model.
module tb_instr_sequencer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        IM_req;
    logic [7:0]  IM_addr;
    logic        IM_ack = 1'b0;
    logic [15:0] IM_rdata = '0;
    logic [3:0]  RF_Ra_addr, RF_Rb_addr, RF_W_addr;
    logic        RF_W_en, RF_W_sel;
    logic [7:0]  D_addr;
    logic        D_wr;
    logic [2:0]  ALU_s;
    logic        Halted, Illegal;
    logic [7:0]  PC_Out;
    logic [15:0] IR_Out;
    logic [7:0]  StateO, NextStateO;

    instr_sequencer #(.PC_W(8), .IR_W(16)) dut (
        .Clk(Clk), .Reset(Reset),
        .IM_req(IM_req), .IM_addr(IM_addr),
        .IM_ack(IM_ack), .IM_rdata(IM_rdata),
        .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr),
        .RF_W_addr(RF_W_addr), .RF_W_en(RF_W_en), .RF_W_sel(RF_W_sel),
        .D_addr(D_addr), .D_wr(D_wr), .ALU_s(ALU_s),
        .Halted(Halted), .Illegal(Illegal),
        .PC_Out(PC_Out), .IR_Out(IR_Out),
        .StateO(StateO), .NextStateO(NextStateO)
    );

    always #5 Clk = ~Clk;

    logic [15:0] mem [256];
    int n_pass = 0;
    int n_tot  = 0;
    int lat = 0;
    int req_cnt = 0;
    bit rand_lat = 0;
    bit ack_idle = 0;
    bit ack_noise = 0;

    // Instruction memory: ack after 'lat' request cycles, ack may be noisy when idle
    task automatic respond();
        if (IM_req) begin
            if (req_cnt == 0 && rand_lat) lat = $urandom_range(0, 3);
            IM_ack   = (req_cnt >= lat);
            IM_rdata = IM_ack ? mem[IM_addr] : 16'($urandom);
            req_cnt++;
        end else begin
            req_cnt  = 0;
            IM_ack   = ack_noise ? 1'($urandom) : ack_idle;
            IM_rdata = 16'($urandom);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        respond();
        #1;
    endtask

    task automatic reset_and_release();
        Reset   = 1'b0;
        IM_ack  = 1'b0;
        req_cnt = 0;
        repeat (2) @(posedge Clk);
        #2;
        Reset = 1'b1;
        respond();
        #1;
    endtask

    task automatic fill_mem(input logic [15:0] v);
        for (int a = 0; a < 256; a++) mem[a] = v;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (2) @(posedge Clk);
        #2;
        n_tot++;
        if ({StateO, PC_Out, IR_Out} !== 32'h0) begin
            $display("FAIL reset_regs got %h want 0", {StateO, PC_Out, IR_Out});
        end else n_pass++;
        n_tot++;
        if ({IM_req, RF_W_en, D_wr, ALU_s, Halted, Illegal} !== 8'h0) begin
            $display("FAIL reset_ctrl got %b want 0",
                     {IM_req, RF_W_en, D_wr, ALU_s, Halted, Illegal});
        end else n_pass++;
        n_tot++;
        if ({RF_Ra_addr, RF_Rb_addr, RF_W_addr, D_addr, IM_addr} !== 28'h0) begin
            $display("FAIL reset_addr got %h want 0",
                     {RF_Ra_addr, RF_Rb_addr, RF_W_addr, D_addr, IM_addr});
        end else n_pass++;
        n_tot++;
        if (NextStateO !== 8'd1) begin
            $display("FAIL reset_next got %0d want 1", NextStateO);
        end else n_pass++;
    endtask

    task automatic test_noop_stream();
        int exp_st[6] = '{0, 1, 3, 1, 3, 1};
        int exp_pc[6] = '{0, 0, 1, 1, 2, 2};
        bit wr = 0;
        fill_mem(16'h0000);
        rand_lat = 0; lat = 0; ack_idle = 1; ack_noise = 0;
        reset_and_release();
        for (int i = 0; i < 6; i++) begin
            n_tot++;
            if (StateO !== 8'(exp_st[i]) || PC_Out !== 8'(exp_pc[i])) begin
                $display("FAIL noop_seq[%0d] got st=%0d pc=%0d want st=%0d pc=%0d",
                         i, StateO, PC_Out, exp_st[i], exp_pc[i]);
            end else n_pass++;
            wr |= D_wr | RF_W_en;
            tick();
        end
        n_tot++;
        if (wr !== 1'b0) $display("FAIL noop_writes got %b want 0", wr);
        else n_pass++;
    endtask

    task automatic test_fetch_latency();
        int n = 0;
        bit addr_ok = 1;
        fill_mem(16'h0000);
        mem[0] = 16'h2105;
        rand_lat = 0; lat = 3; ack_idle = 0; ack_noise = 0;
        reset_and_release();
        tick();
        for (int i = 0; i < 10; i++) begin
            if (IM_req) begin
                n++;
                if (IM_addr !== 8'h00) addr_ok = 0;
            end
            if (IM_req && IM_ack) break;
            tick();
        end
        n_tot++;
        if (n != 4 || !addr_ok) $display("FAIL fetch_wait got req_cycles=%0d addr_ok=%0d want 4 1", n, addr_ok);
        else n_pass++;
        lat = 0;
        tick();
        n_tot++;
        if ({StateO, IR_Out, PC_Out} !== {8'd3, 16'h2105, 8'd1}) begin
            $display("FAIL fetch_ir got %h want 03210501", {StateO, IR_Out, PC_Out});
        end else n_pass++;
        tick();
        n_tot++;
        if ({StateO, D_addr, RF_W_en, D_wr} !== {8'd4, 8'h05, 2'b00}) begin
            $display("FAIL load_a got %h want %h", {StateO, D_addr, RF_W_en, D_wr},
                     {8'd4, 8'h05, 2'b00});
        end else n_pass++;
        tick();
        n_tot++;
        if ({StateO, D_addr, RF_W_addr, RF_W_sel, RF_W_en, D_wr} !==
            {8'd5, 8'h05, 4'd1, 1'b1, 1'b1, 1'b0}) begin
            $display("FAIL load_b got %h want %h",
                     {StateO, D_addr, RF_W_addr, RF_W_sel, RF_W_en, D_wr},
                     {8'd5, 8'h05, 4'd1, 1'b1, 1'b1, 1'b0});
        end else n_pass++;
        tick();
        n_tot++;
        if (StateO !== 8'd1 || RF_W_en !== 1'b0) begin
            $display("FAIL load_done got st=%0d en=%b want 1 0", StateO, RF_W_en);
        end else n_pass++;
    endtask

    task automatic test_alu_ops();
        logic [2:0] exp_s[3] = '{3'b001, 3'b010, 3'b011};
        fill_mem(16'h0000);
        mem[0] = 16'h3123; mem[1] = 16'h4123; mem[2] = 16'h5123;
        rand_lat = 0; lat = 0; ack_idle = 0; ack_noise = 0;
        reset_and_release();
        for (int i = 0; i < 3; i++) begin
            repeat (3) tick();
            n_tot++;
            if ({StateO, ALU_s, RF_Ra_addr, RF_Rb_addr, RF_W_addr, RF_W_en, RF_W_sel, D_wr} !==
                {8'd7, exp_s[i], 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0}) begin
                $display("FAIL alu_op[%0d] got st=%0d s=%b a=%0d b=%0d w=%0d en=%b sel=%b dwr=%b",
                         i, StateO, ALU_s, RF_Ra_addr, RF_Rb_addr, RF_W_addr,
                         RF_W_en, RF_W_sel, D_wr);
            end else n_pass++;
        end
        tick();
        n_tot++;
        if ({StateO, RF_W_en, ALU_s} !== {8'd1, 1'b0, 3'b000}) begin
            $display("FAIL alu_done got st=%0d en=%b s=%b want 1 0 000", StateO, RF_W_en, ALU_s);
        end else n_pass++;
    endtask

    task automatic test_store();
        int pulses = 0;
        fill_mem(16'h0000);
        mem[0] = 16'h1380;
        rand_lat = 0; lat = 0; ack_idle = 0; ack_noise = 0;
        reset_and_release();
        repeat (3) tick();
        n_tot++;
        if ({StateO, D_wr, RF_Ra_addr, D_addr, RF_W_en} !== {8'd6, 1'b1, 4'd3, 8'h80, 1'b0}) begin
            $display("FAIL store got st=%0d dwr=%b ra=%0d da=%h en=%b",
                     StateO, D_wr, RF_Ra_addr, D_addr, RF_W_en);
        end else n_pass++;
        pulses = 1;
        tick();
        n_tot++;
        if ({StateO, IM_req} !== {8'd1, 1'b1}) $display("FAIL store_next got st=%0d req=%b want 1 1", StateO, IM_req);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            if (D_wr) pulses++;
            tick();
        end
        n_tot++;
        if (pulses != 1) $display("FAIL store_pulses got %0d want 1", pulses);
        else n_pass++;
    endtask

    task automatic test_halt();
        bit stuck = 1;
        fill_mem(16'h0000);
        mem[0] = 16'h6000;
        rand_lat = 0; lat = 0; ack_idle = 1; ack_noise = 0;
        reset_and_release();
        repeat (3) tick();
        for (int i = 0; i < 12; i++) begin
            if (StateO !== 8'd8 || Halted !== 1'b1 || IM_req !== 1'b0 ||
                RF_W_en !== 1'b0 || D_wr !== 1'b0 || PC_Out !== 8'd1) stuck = 0;
            tick();
        end
        n_tot++;
        if (!stuck) $display("FAIL halt_hold got st=%0d halted=%b req=%b want 8 1 0", StateO, Halted, IM_req);
        else n_pass++;
        #2;
        Reset = 1'b0;
        #1;
        n_tot++;
        if ({StateO, PC_Out, Halted} !== {8'd0, 8'd0, 1'b0}) begin
            $display("FAIL halt_reset got st=%0d pc=%0d halted=%b want 0 0 0", StateO, PC_Out, Halted);
        end else n_pass++;
    endtask

    task automatic test_illegal();
        int pulses = 0;
        bit wr = 0;
        fill_mem(16'h0000);
        mem[0] = 16'hF000;
        rand_lat = 0; lat = 0; ack_idle = 0; ack_noise = 0;
        reset_and_release();
        repeat (2) tick();
        n_tot++;
        if ({StateO, Illegal, NextStateO} !== {8'd3, 1'b1, 8'd1}) begin
            $display("FAIL illegal_decode got st=%0d ill=%b nxt=%0d want 3 1 1", StateO, Illegal, NextStateO);
        end else n_pass++;
        for (int i = 0; i < 8; i++) begin
            if (Illegal) pulses++;
            wr |= D_wr | RF_W_en;
            tick();
        end
        n_tot++;
        if (pulses != 1 || wr) $display("FAIL illegal_pulse got pulses=%0d wr=%b want 1 0", pulses, wr);
        else n_pass++;
    endtask

    task automatic test_pc_wrap();
        bit seen = 0;
        fill_mem(16'h0000);
        rand_lat = 0; lat = 0; ack_idle = 0; ack_noise = 0;
        reset_and_release();
        for (int i = 0; i < 700; i++) begin
            tick();
            if (IM_req && IM_ack && PC_Out == 8'hFF) begin
                seen = 1;
                tick();
                n_tot++;
                if (PC_Out !== 8'h00) $display("FAIL pc_wrap got %h want 00", PC_Out);
                else n_pass++;
                break;
            end
        end
        n_tot++;
        if (!seen) $display("FAIL pc_reach_ff got %0d want 1", seen);
        else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        fill_mem(16'h0000);
        mem[0] = 16'h5123;
        rand_lat = 0; lat = 0; ack_idle = 0; ack_noise = 0;
        reset_and_release();
        repeat (2) tick();
        lat = 50;
        repeat (3) tick();
        n_tot++;
        if ({StateO, IM_req, IM_addr, IR_Out} !== {8'd2, 1'b1, 8'd1, 16'h5123}) begin
            $display("FAIL wait_state got st=%0d req=%b addr=%0d ir=%h", StateO, IM_req, IM_addr, IR_Out);
        end else n_pass++;
        #2;
        Reset = 1'b0;
        #1;
        n_tot++;
        if ({IM_req, StateO, PC_Out, IR_Out, RF_Ra_addr, RF_W_en, D_wr, ALU_s, Halted} !== 42'h0) begin
            $display("FAIL wait_reset got req=%b st=%0d pc=%0d ir=%h ra=%0d",
                     IM_req, StateO, PC_Out, IR_Out, RF_Ra_addr);
        end else n_pass++;
        lat = 0;
    endtask

    // Instruction-level reference: each fetched word yields a fixed path
    // length and a fixed set of datapath effects derived from its opcode.
    task automatic test_random_program();
        logic [7:0]  exp_pc;
        logic [15:0] ins;
        logic [3:0]  op;
        int k, rfw, dwr, ill, bad, e_k, e_rfw, e_dwr, e_ill;
        logic [14:0] alu_seen, alu_exp;
        logic [16:0] ld_seen, ld_exp;
        logic [11:0] st_seen, st_exp;
        logic [15:0] ir_seen;
        for (int a = 0; a < 256; a++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'h6) op = 4'h0;
            mem[a] = {op, 12'($urandom)};
        end
        rand_lat = 1; ack_idle = 0; ack_noise = 1;
        reset_and_release();
        exp_pc = 8'h00;
        for (int n = 0; n < 160; n++) begin
            k = 0;
            while (!(IM_req && IM_ack) && k < 12) begin
                tick();
                k++;
            end
            if (!(IM_req && IM_ack)) begin
                n_tot++;
                $display("FAIL rand_fetch_timeout got no ack at instr %0d", n);
                break;
            end
            n_tot++;
            if (IM_addr !== exp_pc) $display("FAIL rand_addr got %h want %h", IM_addr, exp_pc);
            else n_pass++;
            ins = mem[exp_pc];
            exp_pc = exp_pc + 8'd1;
            op = ins[15:12];
            k = 0; rfw = 0; dwr = 0; ill = 0; bad = 0;
            alu_seen = '0; ld_seen = '0; st_seen = '0; ir_seen = '0;
            do begin
                tick();
                k++;
                if (k == 1) ir_seen = IR_Out;
                if (RF_W_en) begin
                    rfw++;
                    alu_seen = {RF_W_addr, RF_W_sel, ALU_s, RF_Ra_addr, RF_Rb_addr};
                    ld_seen  = {RF_W_addr, RF_W_sel, ALU_s, D_addr, 1'b0};
                end
                if (D_wr) begin
                    dwr++;
                    st_seen = {D_addr, RF_Ra_addr};
                end
                if (Illegal) ill++;
                if ((D_wr && RF_W_en) || Halted) bad++;
            end while (!IM_req && k < 8);
            e_rfw = 0; e_dwr = 0; e_ill = 0;
            alu_exp = '0; ld_exp = '0; st_exp = '0;
            if (op == 4'h0) e_k = 2;
            else if (op == 4'h1) begin
                e_k = 3; e_dwr = 1; st_exp = {ins[7:0], ins[11:8]};
            end else if (op == 4'h2) begin
                e_k = 4; e_rfw = 1; ld_exp = {ins[11:8], 1'b1, 3'b000, ins[7:0], 1'b0};
            end else if (op >= 4'h3 && op <= 4'h5) begin
                e_k = 3; e_rfw = 1;
                alu_exp = {ins[3:0], 1'b0, 3'(op - 4'h2), ins[11:8], ins[7:4]};
            end else begin
                e_k = 2; e_ill = 1;
            end
            n_tot++;
            if (k != e_k || rfw != e_rfw || dwr != e_dwr || ill != e_ill || bad != 0) begin
                $display("FAIL rand_shape ins=%h got k=%0d rfw=%0d dwr=%0d ill=%0d bad=%0d want %0d %0d %0d %0d 0",
                         ins, k, rfw, dwr, ill, bad, e_k, e_rfw, e_dwr, e_ill);
            end else n_pass++;
            n_tot++;
            if (ir_seen !== ins || PC_Out !== exp_pc) begin
                $display("FAIL rand_ir got ir=%h pc=%h want %h %h", ir_seen, PC_Out, ins, exp_pc);
            end else n_pass++;
            if (e_rfw == 1 && op != 4'h2) begin
                n_tot++;
                if (alu_seen !== alu_exp) $display("FAIL rand_alu got %h want %h", alu_seen, alu_exp);
                else n_pass++;
            end
            if (op == 4'h2) begin
                n_tot++;
                if (ld_seen !== ld_exp) $display("FAIL rand_load got %h want %h", ld_seen, ld_exp);
                else n_pass++;
            end
            if (e_dwr == 1) begin
                n_tot++;
                if (st_seen !== st_exp) $display("FAIL rand_store got %h want %h", st_seen, st_exp);
                else n_pass++;
            end
        end
        ack_noise = 0;
        rand_lat = 0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_mem(16'h0000);
        test_reset();
        test_noop_stream();
        test_fetch_latency();
        test_alu_ops();
        test_store();
        test_halt();
        test_illegal();
        test_pc_wrap();
        test_reset_in_wait();
        test_random_program();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
